// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR multiply-accumulate controller.
package fir_pkg;

  localparam int TAPS   = 11;
  localparam int ADDR_W = 4;
  localparam int COEF_W = 16;
  localparam int IN_W   = 8;
  localparam int ACC_W  = 28;

  // Full-precision signed product of one sample and one coefficient.
  localparam int PROD_W = IN_W + COEF_W;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // FSM state encodings.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  typedef logic signed [IN_W-1:0] sample_t;

endpackage

// File: rtl/fir_tap_delay_line.sv
// 11-tap signed sample delay line; shifts one position per enable pulse.
module fir_tap_delay_line
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    shift_en,
  input  sample_t din,
  output sample_t taps [TAPS]
);

  sample_t taps_q [TAPS];
  sample_t taps_d [TAPS];

  // Next-state: newest sample enters tap 0, older samples move up by one.
  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int k = 1; k < TAPS; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  // Tap registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequential FIR MAC engine: reads 11 coefficients from a registered-read
// SRAM per sample and accumulates them against the tap delay line.
// Optional build macro FIR_OVERRUN_FLAG_EN adds a sticky oOverrun output
// that records strobes dropped while busy.
//
// state | meaning
// IDLE  | waiting for sample strobe; SRAM port released (oCsnRam=1)
// READ  | presenting addresses 0..10, accumulating coef(addr-1)*tap(addr-1)
// LAST  | final coefficient arrives; publish result and pulse oFirValid
module fir_mac_ctrl
  import fir_pkg::*;
(
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample,
  input  logic signed [IN_W-1:0]   iFirIn,
  output logic                     oCsnRam,
  output logic                     oWrnRam,
  output logic [ADDR_W-1:0]        oAddrRam,
  input  logic signed [COEF_W-1:0] iRdDtRam,
  output logic signed [ACC_W-1:0]  oFirOut,
  output logic                     oFirValid,
  output logic                     oBusy
`ifdef FIR_OVERRUN_FLAG_EN
  ,
  output logic                     oOverrun
`endif
);

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    csn_q, csn_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    shift_en;

  sample_t                  taps [TAPS];
  logic [ADDR_W-1:0]        tap_idx;
  sample_t                  tap_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  fir_tap_delay_line u_delay (
    .clk      (iClk12M),
    .rst_n    (iRsn),
    .shift_en (shift_en),
    .din      (iFirIn),
    .taps     (taps)
  );

  // Returned data always belongs to the address presented one cycle ago;
  // in LAST the address register holds at 10, which is that address.
  always_comb begin
    tap_idx = (state_q == LAST) ? addr_q : (addr_q - ADDR_ONE);
    tap_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_idx == k[ADDR_W-1:0]) begin
        tap_sel = taps[k];
      end
    end
    prod     = PROD_W'(iRdDtRam) * PROD_W'(tap_sel);
    prod_ext = ACC_W'(prod);
  end

  // Sequencer and accumulator next-state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    csn_d    = csn_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEnSample) begin
          shift_en = 1'b1;
          acc_d    = '0;
          addr_d   = '0;
          csn_d    = 1'b0;
          state_d  = READ;
        end
      end
      READ: begin
        // Nothing has come back from the SRAM yet on the first READ edge.
        if (addr_q != '0) begin
          acc_d = acc_q + prod_ext;
        end
        if (addr_q == ADDR_LAST) begin
          csn_d   = 1'b1;
          state_d = LAST;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      LAST: begin
        out_d   = acc_q + prod_ext;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        csn_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      csn_q   <= 1'b1;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      csn_q   <= csn_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign oCsnRam   = csn_q;
  assign oWrnRam   = 1'b1;
  assign oAddrRam  = addr_q;
  assign oFirOut   = out_q;
  assign oFirValid = valid_q;
  assign oBusy     = (state_q != IDLE);

`ifdef FIR_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  // Sticky record of any strobe that arrived while a sample was in flight.
  always_comb begin
    overrun_d = overrun_q | (iEnSample & oBusy);
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign oOverrun = overrun_q;
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl with a registered-read coefficient SRAM.
module tb_fir_mac_ctrl;
  import fir_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     en = 1'b0;
  logic signed [IN_W-1:0]   fir_in = '0;
  logic                     csn, wrn;
  logic [ADDR_W-1:0]        addr;
  logic signed [COEF_W-1:0] rd_dt = '0;
  logic signed [ACC_W-1:0]  fir_out;
  logic                     fir_valid, busy;
`ifdef FIR_OVERRUN_FLAG_EN
  logic                     overrun;
`endif

  logic [COEF_W-1:0] coef_mem [16];
  int n_checks = 0;
  int n_pass = 0;

  fir_mac_ctrl dut (
    .iClk12M   (clk),
    .iRsn      (rst_n),
    .iEnSample (en),
    .iFirIn    (fir_in),
    .oCsnRam   (csn),
    .oWrnRam   (wrn),
    .oAddrRam  (addr),
    .iRdDtRam  (rd_dt),
    .oFirOut   (fir_out),
    .oFirValid (fir_valid),
    .oBusy     (busy)
`ifdef FIR_OVERRUN_FLAG_EN
    ,
    .oOverrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  // Coefficient SRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (!csn) rd_dt <= coef_mem[addr];
  end

  task automatic set_coefs(input logic [COEF_W-1:0] c0, input logic [COEF_W-1:0] rest);
    coef_mem[0] = c0;
    for (int k = 1; k < 16; k++) coef_mem[k] = rest;
  endtask

  // Strobe a sample at the current negedge and wait for the result.
  // lat counts rising edges after the accepting edge until oFirValid is seen.
  task automatic run_sample(input logic signed [IN_W-1:0] s,
                            output logic signed [ACC_W-1:0] res,
                            output int lat, output int csn_cnt,
                            output bit addr_ok, output bit accept_ok);
    fir_in = s;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    accept_ok = (busy === 1'b1) && (fir_valid === 1'b0);
    lat = 0;
    csn_cnt = 0;
    addr_ok = 1'b1;
    while (fir_valid !== 1'b1 && lat < 30) begin
      if (csn === 1'b0) begin
        csn_cnt++;
        if (addr !== lat[ADDR_W-1:0]) addr_ok = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    res = fir_out;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (fir_out !== '0 || fir_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs out=%0d valid=%0b busy=%0b required 0/0/0", fir_out, fir_valid, busy);
    else n_pass++;
    n_checks++;
    if (csn !== 1'b1 || wrn !== 1'b1 || addr !== 4'd0)
      $display("FAIL reset_sram csn=%0b wrn=%0b addr=%0d required 1/1/0", csn, wrn, addr);
    else n_pass++;
`ifdef FIR_OVERRUN_FLAG_EN
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun got=%0b required 0", overrun);
    else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wrn !== 1'b1 || csn !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_reset wrn=%0b csn=%0b busy=%0b required 1/1/0", wrn, csn, busy);
    else n_pass++;
  endtask

  task automatic test_impulse();
    logic signed [ACC_W-1:0] res;
    int lat, cc;
    bit aok, acc_ok;
    for (int k = 0; k < 16; k++) coef_mem[k] = COEF_W'(k + 1);
    for (int j = 0; j < TAPS; j++) begin
      run_sample((j == 0) ? 8'sd1 : 8'sd0, res, lat, cc, aok, acc_ok);
      n_checks++;
      if (res !== ACC_W'(j + 1)) $display("FAIL impulse_out[%0d] got=%0d required %0d", j, res, j + 1);
      else n_pass++;
      n_checks++;
      if (lat !== 12) $display("FAIL impulse_latency[%0d] got=%0d required 12", j, lat);
      else n_pass++;
      n_checks++;
      if (!acc_ok) $display("FAIL impulse_accept[%0d] busy=%0b valid=%0b required 1/0", j, busy, fir_valid);
      else n_pass++;
      if (j == 0) begin
        n_checks++;
        if (cc !== 11) $display("FAIL impulse_csn_cycles got=%0d required 11", cc);
        else n_pass++;
        n_checks++;
        if (!aok) $display("FAIL impulse_addr_trace got=bad required 0..10");
        else n_pass++;
      end
    end
  endtask

  task automatic test_running_sum();
    logic signed [ACC_W-1:0] res;
    int lat, cc;
    bit aok, acc_ok;
    set_coefs(16'd1, 16'd1);
    for (int j = 1; j <= TAPS; j++) run_sample(IN_W'(j), res, lat, cc, aok, acc_ok);
    n_checks++;
    if (res !== 28'sd66) $display("FAIL running_sum got=%0d required 66", res);
    else n_pass++;
    n_checks++;
    if (cc !== 11 || !aok) $display("FAIL running_sum_trace csn_cycles=%0d addr_ok=%0b required 11/1", cc, aok);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fir_valid !== 1'b0) $display("FAIL valid_pulse_width got=%0b required 0", fir_valid);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic signed [ACC_W-1:0] res, expv;
    int lat, cc;
    bit aok, acc_ok;
    expv = -200;
    set_coefs(16'hFFFE, 16'h0000);
    run_sample(8'sd100, res, lat, cc, aok, acc_ok);
    n_checks++;
    if (res !== expv) $display("FAIL signed_out got=%0d required -200", res);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (fir_out !== expv || fir_valid !== 1'b0)
      $display("FAIL output_hold got=%0d valid=%0b required -200/0", fir_out, fir_valid);
    else n_pass++;
  endtask

  task automatic test_extreme();
    logic signed [ACC_W-1:0] res;
    int lat, cc;
    bit aok, acc_ok;
    set_coefs(16'h8000, 16'h8000);
    for (int j = 0; j < TAPS; j++) run_sample(-8'sd128, res, lat, cc, aok, acc_ok);
    n_checks++;
    if (res !== 28'sd46137344) $display("FAIL extreme_out got=%0d required 46137344", res);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic signed [ACC_W-1:0] res;
    int lat, cc;
    bit aok, acc_ok;
    set_coefs(16'd2, 16'd0);
    fir_in = 8'sd10;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    fir_in = 8'sd50;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    lat = 5;
    while (fir_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (fir_out !== 28'sd20 || lat !== 12)
      $display("FAIL overrun_first got=%0d lat=%0d required 20 lat=12", fir_out, lat);
    else n_pass++;
`ifdef FIR_OVERRUN_FLAG_EN
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_flag got=%0b required 1", overrun);
    else n_pass++;
`endif
    coef_mem[0] = 16'd0;
    coef_mem[1] = 16'd1;
    run_sample(8'sd0, res, lat, cc, aok, acc_ok);
    n_checks++;
    if (res !== 28'sd10) $display("FAIL overrun_taps got=%0d required 10", res);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic signed [ACC_W-1:0] res;
    int lat, cc;
    bit aok, acc_ok, seen;
    fir_in = 8'sd5;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (csn !== 1'b1 || fir_out !== '0 || busy !== 1'b0 || fir_valid !== 1'b0)
      $display("FAIL midreset_state csn=%0b out=%0d busy=%0b valid=%0b required 1/0/0/0", csn, fir_out, busy, fir_valid);
    else n_pass++;
`ifdef FIR_OVERRUN_FLAG_EN
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL midreset_overrun got=%0b required 0", overrun);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (fir_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || csn !== 1'b1) $display("FAIL midreset_no_valid seen=%0b csn=%0b required 0/1", seen, csn);
    else n_pass++;
    coef_mem[0] = 16'd3;
    coef_mem[1] = 16'd5;
    for (int k = 2; k < 16; k++) coef_mem[k] = 16'd0;
    run_sample(8'sd7, res, lat, cc, aok, acc_ok);
    n_checks++;
    if (res !== 28'sd21 || lat !== 12) $display("FAIL midreset_rerun got=%0d lat=%0d required 21 lat=12", res, lat);
    else n_pass++;
  endtask

  initial begin
    set_coefs(16'd0, 16'd0);
    test_reset();
    test_impulse();
    test_running_sum();
    test_signed();
    test_extreme();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_ctrl.md
Name: fir_mac_ctrl

Overview:
- Sequential multiply-accumulate engine of the FIR filter. Sits directly downstream of the 11-entry coefficient SRAM.
- On each input sample strobe, it does four things:
  - shifts the sample into an 11-tap delay line;
  - sequences reads of coefficient addresses 0..10 from the SRAM;
  - multiply-accumulates each returned coefficient with the matching tap;
  - emits one filtered output with a one-cycle valid pulse.
- The SRAM's 1-cycle registered read latency is absorbed internally.

Parameters:
- TAPS, 11: number of filter taps; also the number of coefficient reads per sample.
- IN_W, 8: signed input sample width.
- COEF_W, 16: signed coefficient width; matches the SRAM data width.
- ACC_W, 28: signed accumulator and output width (IN_W + COEF_W + 4 guard bits).

Ports:
- iClk12M  in  1  system clock, 12 MHz.
- iRsn  in  1  reset, asynchronous, active-low.
- iEnSample  in  1  one-cycle sample strobe.
- iFirIn  in  IN_W  signed input sample; valid when iEnSample=1.
- oCsnRam  out  1  SRAM chip select, active-low.
- oWrnRam  out  1  SRAM write enable, active-low; this block never writes.
- oAddrRam  out  4  SRAM coefficient address.
- iRdDtRam  in  COEF_W  SRAM read data; valid one cycle after the address is presented with oCsnRam=0.
- oFirOut  out  ACC_W  signed filter result.
- oFirValid  out  1  one-cycle pulse, oFirOut valid.
- oBusy  out  1  high from the accepted strobe until oFirValid.

Behaviour:
- Reset (iRsn=0, asynchronous):
  - state IDLE; delay line, accumulator and tap index cleared to 0.
  - oFirOut=0, oFirValid=0, oBusy=0.
  - oCsnRam=1, oWrnRam=1, oAddrRam=0.
- oWrnRam is constant 1 outside reset as well.
- State IDLE:
  - oCsnRam=1, oBusy=0.
  - iEnSample=1 at edge E0: tap[k]<=tap[k-1] for k=1..10, tap[0]<=iFirIn, accumulator<=0, oAddrRam<=0, oCsnRam<=0, go to READ.
- State READ:
  - Each edge: oAddrRam increments by 1.
  - From the second READ edge onward, accumulator += signed(iRdDtRam) * signed(tap[oAddrRam-1]).
  - The edge that presents address 10 and captures coefficient 10 (E11): oCsnRam<=1, go to LAST.
- State LAST (edge E12):
  - oFirOut <= accumulator + coef10*tap[10].
  - oFirValid<=1 for exactly one cycle; go to IDLE.
- Latency: oFirValid is high in the cycle following E12, i.e. 12 clock edges after the accepted strobe. The minimum sample spacing is 13 cycles.
- Arithmetic:
  - Full-precision signed products (IN_W+COEF_W bits), sign-extended to ACC_W.
  - No truncation, rounding or saturation. The worst case (11 × 32768 × 128) fits ACC_W=28.
- oFirOut holds its value until the next completion.
- iEnSample while oBusy=1: ignored. The delay line, accumulator and sequence are unaffected and the sample is lost.
- iEnSample in the same cycle oFirValid=1: state is IDLE, so the strobe is accepted normally.
- Reset mid-operation: immediate return to IDLE, no oFirValid pulse, delay line cleared.
- oAddrRam never exceeds TAPS-1.
- While IDLE, oCsnRam=1, so an external coefficient loader may own the SRAM port. Arbitration is outside this block and uses oBusy.

Optional Feature:
- Macro: FIR_OVERRUN_FLAG_EN.
- Defined:
  - Adds output oOverrun (1 bit, reset 0).
  - Set sticky to 1 when iEnSample=1 while oBusy=1.
  - Cleared only by reset.
- Undefined: no port; dropped strobes are silent. All other behaviour is identical.

Decomposition:
- Package fir_pkg holds:
  - TAPS=11, ADDR_W=4, COEF_W=16, IN_W=8, ACC_W=28;
  - state enum IDLE/READ/LAST;
  - the signed product-width localparam.
- One sub-module: fir_tap_delay_line (shift-enable plus an 11×IN_W signed register array, async active-low clear). The FSM and MAC stay in fir_mac_ctrl.

Test Plan:
- Impulse response: SRAM coef[k]=k+1; sample 1 then ten samples of 0, each 13 cycles apart -> outputs 1,2,...,11, each with oFirValid exactly 12 edges after its strobe.
- Running sum: all coefs 1; samples 1..11 -> 11th output = 66; address trace per run is 0..10 with oCsnRam low for exactly 11 cycles.
- Signed: coef0=16'hFFFE, all other coefs 0; sample 100 -> oFirOut = -200 (sign-extended to 28 bits).
- Extreme: all coefs 16'h8000; eleven samples of -128 -> final output = +46137344, no overflow.
- Overrun: second strobe 5 cycles after the first -> ignored, first result unchanged; oOverrun=1 when the macro is defined.
- Reset at cycle 6 of a run -> no oFirValid pulse, oCsnRam=1, outputs 0; a following strobe with sample 7 and coef0=3 -> 21.
